// File: rtl/rom_writer_if.sv
// Host and PROM-pin signal bundle for rom_writer. The slave modport is the
// writer's own view; the master modport is the host/chip side.
interface rom_writer_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9
);
    // Handshake: start is a level request taken only while busy=0 and the
    // writer is idle; busy=1 means not ready, and done/error report the
    // outcome until the next accepted start.
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [DATA_WIDTH-1:0]    data_line_in;
    logic [ADDRESS_WIDTH-1:0] address_line;
    logic [DATA_WIDTH-1:0]    data_line;
    logic                     data_oe;
    logic                     program_pulse;
    logic                     chip_select_n;
    logic                     busy;
    logic                     done;
    logic                     error;
    logic [3:0]               operation;

    modport slave (
        input  start, write_address, write_data, data_line_in,
        output address_line, data_line, data_oe, program_pulse,
               chip_select_n, busy, done, error, operation
    );

    modport master (
        output start, write_address, write_data, data_line_in,
        input  address_line, data_line, data_oe, program_pulse,
               chip_select_n, busy, done, error, operation
    );
endinterface

// File: rtl/rom_writer.sv
// Bipolar fuse PROM word programmer: blows fuses one bit at a time with a
// timed strobe and read-back verify, retrying a bounded number of times.
module rom_writer #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 9,
    parameter int BLANK_VALUE    = 0,
    parameter int SETUP_CYCLES   = 4,
    parameter int PULSE_CYCLES   = 50,
    parameter int RECOVER_CYCLES = 4,
    parameter int READ_CYCLES    = 4,
    parameter int MAX_RETRIES    = 3
) (
    input logic clk,
    input logic reset_n,
    rom_writer_if.slave bus
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PRE_READ = 4'd1,
        ST_SETUP    = 4'd2,
        ST_PULSE    = 4'd3,
        ST_RECOVER  = 4'd4,
        ST_VERIFY   = 4'd5,
        ST_NEXT_BIT = 4'd6,
        ST_DONE     = 4'd7,
        ST_FAIL     = 4'd8
    } state_t;

    localparam int MAX_AB    = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_CD    = (RECOVER_CYCLES > READ_CYCLES) ? RECOVER_CYCLES : READ_CYCLES;
    localparam int MAX_DELAY = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int RW        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int IW        = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] BLANK_WORD = (BLANK_VALUE != 0) ? '1 : '0;

    state_t                   state, state_next;
    logic [TW-1:0]            timer;
    logic [IW-1:0]            bit_idx;
    logic [RW-1:0]            retry;
    logic [DATA_WIDTH-1:0]    cur_word;
    logic [DATA_WIDTH-1:0]    tgt_word;
    logic [ADDRESS_WIDTH-1:0] addr_r;
    logic                     done_r;
    logic                     error_r;

    int                       delay_limit;
    logic                     delay_last;
    logic [DATA_WIDTH-1:0]    need_mask;
    logic                     found;
    logic [IW-1:0]            found_idx;
    logic [DATA_WIDTH-1:0]    sel_mask;
    logic                     read_bit;
    logic                     tgt_bit;
    logic                     pre_read_bad;

    // Combinational view of the word and the bit under programming.
    always_comb begin
        sel_mask     = DATA_WIDTH'(1) << bit_idx;
        read_bit     = |(bus.data_line_in & sel_mask);
        tgt_bit      = |(tgt_word & sel_mask);
        // A bit the target leaves blank but the chip already has blown is unrecoverable.
        pre_read_bad = |(~(tgt_word ^ BLANK_WORD) & (bus.data_line_in ^ BLANK_WORD));
        need_mask    = (tgt_word ^ BLANK_WORD) & (cur_word ^ tgt_word);
        found        = 1'b0;
        found_idx    = '0;
        // Descending scan so the lowest qualifying bit at or above bit_idx wins.
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (need_mask[i] && (i >= int'(bit_idx))) begin
                found     = 1'b1;
                found_idx = IW'(i);
            end
        end
    end

    always_comb begin
        delay_limit = 1;
        case (state)
            ST_PRE_READ, ST_VERIFY: delay_limit = READ_CYCLES;
            ST_SETUP:               delay_limit = SETUP_CYCLES;
            ST_PULSE:               delay_limit = PULSE_CYCLES;
            ST_RECOVER:             delay_limit = RECOVER_CYCLES;
            default:                delay_limit = 1;
        endcase
        delay_last = (int'(timer) >= delay_limit - 1);
    end

    // Next-state logic and pin/status decode.
    always_comb begin
        state_next         = state;
        bus.busy           = 1'b1;
        bus.chip_select_n  = 1'b0;
        bus.data_oe        = 1'b0;
        bus.data_line      = '0;
        bus.program_pulse  = 1'b0;
        bus.address_line   = addr_r;
        bus.done           = done_r;
        bus.error          = error_r;
        bus.operation      = state;
        case (state)
            ST_IDLE: begin
                bus.busy          = 1'b0;
                bus.chip_select_n = 1'b1;
                if (bus.start) state_next = ST_PRE_READ;
            end
            ST_PRE_READ: begin
                if (delay_last) state_next = pre_read_bad ? ST_FAIL : ST_NEXT_BIT;
            end
            ST_NEXT_BIT: begin
                state_next = found ? ST_SETUP : ST_DONE;
            end
            ST_SETUP: begin
                bus.data_oe   = 1'b1;
                bus.data_line = sel_mask;
                if (delay_last) state_next = ST_PULSE;
            end
            ST_PULSE: begin
                bus.data_oe       = 1'b1;
                bus.data_line     = sel_mask;
                bus.program_pulse = 1'b1;
                if (delay_last) state_next = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (delay_last) state_next = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (delay_last) begin
                    if (read_bit == tgt_bit)          state_next = ST_NEXT_BIT;
                    else if (retry < RW'(MAX_RETRIES)) state_next = ST_SETUP;
                    else                               state_next = ST_FAIL;
                end
            end
            ST_DONE, ST_FAIL: begin
                bus.busy          = 1'b0;
                bus.chip_select_n = 1'b1;
                state_next        = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            retry    <= '0;
            cur_word <= '0;
            tgt_word <= '0;
            addr_r   <= '0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state <= state_next;
            timer <= (state_next != state) ? '0 : timer + 1'b1;
            if (state_next == ST_DONE) done_r  <= 1'b1;
            if (state_next == ST_FAIL) error_r <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        addr_r   <= bus.write_address;
                        tgt_word <= bus.write_data;
                        done_r   <= 1'b0;
                        error_r  <= 1'b0;
                    end
                end
                ST_PRE_READ: begin
                    if (delay_last) begin
                        cur_word <= bus.data_line_in;
                        bit_idx  <= '0;
                        retry    <= '0;
                    end
                end
                ST_NEXT_BIT: begin
                    if (found) bit_idx <= found_idx;
                end
                ST_VERIFY: begin
                    if (delay_last) begin
                        if (read_bit == tgt_bit) begin
                            cur_word <= (cur_word & ~sel_mask) | (read_bit ? sel_mask : '0);
                            retry    <= '0;
                            bit_idx  <= bit_idx + 1'b1;
                        end else if (retry < RW'(MAX_RETRIES)) begin
                            retry <= retry + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_writer.sv
// Directed bench for rom_writer: a fuse-PROM chip model, an outcome model
// built from the programming rules, and a per-cycle protocol monitor.
module tb_rom_writer;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int SETUP = 4;
  localparam int PULSE = 50;
  localparam int RECOVER = 4;
  localparam int READ = 4;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  logic reset_n;

  rom_writer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  rom_writer #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLANK_VALUE(0),
    .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE), .RECOVER_CYCLES(RECOVER),
    .READ_CYCLES(READ), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // chip model: a bit reads 1 once it has taken need[i] pulses (0 = never)
  logic [DW-1:0] chip_init = '0;
  int need [DW];
  int pulse_cnt [DW];
  logic [DW-1:0] chip_bit;

  always_comb begin
    chip_bit = chip_init;
    for (int i = 0; i < DW; i++)
      if (need[i] != 0 && pulse_cnt[i] >= need[i]) chip_bit[i] = 1'b1;
  end
  assign bus.data_line_in = chip_bit;

  logic [DW-1:0] exp_q[$];
  logic exp_fail;
  logic [AW-1:0] exp_addr = '0;
  logic mon_en = 1'b1;
  int pulses_seen = 0;
  logic [15:0] seen_ops = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_dur(input logic [3:0] op);
    case (op)
      4'd1, 4'd5: return READ;
      4'd2: return SETUP;
      4'd3: return PULSE;
      4'd4: return RECOVER;
      4'd6, 4'd7, 4'd8: return 1;
      default: return 0;
    endcase
  endfunction

  // Outcome model: fill exp_q with the expected one-hot pulse sequence.
  function automatic int model_op(input logic [DW-1:0] init, input logic [DW-1:0] tgt);
    int n = 0;
    int k;
    exp_q.delete();
    exp_fail = 1'b0;
    if ((~tgt & init) != '0) begin
      exp_fail = 1'b1;
      return 0;
    end
    for (int i = 0; i < DW; i++) begin
      if (tgt[i] && !init[i]) begin
        k = (need[i] == 0 || need[i] > 1 + MAXR) ? 1 + MAXR : need[i];
        for (int j = 0; j < k; j++) exp_q.push_back(DW'(1) << i);
        n += k;
        if (need[i] == 0 || need[i] > 1 + MAXR) begin
          exp_fail = 1'b1;
          return n;
        end
      end
    end
    return n;
  endfunction

  // Per-cycle monitor: pin invariants, state durations, pulse scoreboard.
  initial begin
    logic [3:0] prev_op = '0;
    int run_len = 0;
    logic prev_pp = 1'b0;
    int pulse_len = 0;
    logic [DW-1:0] last_line = '0;
    logic [3:0] cur_op;
    for (int i = 0; i < DW; i++) pulse_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || !mon_en) begin
        prev_op = '0;
        run_len = 0;
        prev_pp = 1'b0;
        continue;
      end
      cur_op = bus.operation;
      check("busy_vs_csn", {31'd0, bus.busy}, {31'd0, ~bus.chip_select_n});
      if (bus.program_pulse) begin
        check("pulse_needs_oe", {31'd0, bus.data_oe}, 32'd1);
        check("pulse_needs_cs", {31'd0, bus.chip_select_n}, 32'd0);
      end
      if (bus.busy) check("addr_hold", {23'd0, bus.address_line}, {23'd0, exp_addr});
      if (cur_op == prev_op) run_len++;
      else begin
        if (prev_op != 4'd0)
          check($sformatf("dur_op%0d", prev_op), run_len, exp_dur(prev_op));
        if (cur_op == 4'd1) begin
          for (int i = 0; i < DW; i++) pulse_cnt[i] = 0;
          pulses_seen = 0;
          seen_ops = '0;
        end
        seen_ops[cur_op] = 1'b1;
        prev_op = cur_op;
        run_len = 1;
      end
      if (bus.program_pulse && !prev_pp) begin
        pulses_seen++;
        pulse_len = 1;
        last_line = bus.data_line;
        if (exp_q.size() == 0) check("unexpected_pulse", {24'd0, bus.data_line}, 32'd0);
        else check("pulse_line", {24'd0, bus.data_line}, {24'd0, exp_q.pop_front()});
      end else if (bus.program_pulse) begin
        pulse_len++;
      end else if (prev_pp) begin
        check("pulse_len", pulse_len, PULSE);
        for (int i = 0; i < DW; i++) if (last_line[i]) pulse_cnt[i]++;
      end
      prev_pp = bus.program_pulse;
    end
  end

  task automatic run_op(input logic [AW-1:0] addr, input logic [DW-1:0] tgt,
                        input int exp_n, output int cycles);
    @(negedge clk);
    exp_addr = addr;
    bus.write_address = addr;
    bus.write_data = tgt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles = 0;
    while (bus.busy && cycles < 5000) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 5000) check("op_timeout", cycles, 0);
    @(negedge clk);
    check("done_flag", {31'd0, bus.done}, {31'd0, ~exp_fail});
    check("error_flag", {31'd0, bus.error}, {31'd0, exp_fail});
    check("pulse_count", pulses_seen, exp_n);
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int cyc;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.write_address = '0;
    bus.write_data = '0;
    for (int i = 0; i < DW; i++) need[i] = 1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_operation", {28'd0, bus.operation}, 32'd0);
    check("rst_csn", {31'd0, bus.chip_select_n}, 32'd1);
    check("rst_busy_done_err", {29'd0, bus.busy, bus.done, bus.error}, 32'd0);
    check("rst_pins", {22'd0, bus.data_oe, bus.program_pulse, bus.data_line}, 32'd0);
    check("rst_address", {23'd0, bus.address_line}, 32'd0);

    // blank chip, 0xA5: four single pulses, lowest bit first
    chip_init = 8'h00;
    n = model_op(8'h00, 8'hA5);
    check("model_t2_n", n, 4);
    check("model_t2_seq", {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}, 32'h01042080);
    run_op(9'h1A5, 8'hA5, n, cyc);
    check("t2_done_lit", {31'd0, bus.done}, 32'd1);
    check("t2_chip_word", {24'd0, chip_bit}, 32'hA5);

    // pre-programmed bit the target leaves blank: fail straight from pre-read
    chip_init = 8'h01;
    n = model_op(8'h01, 8'hF0);
    check("model_t3_fail", {31'd0, exp_fail}, 32'd1);
    run_op(9'h033, 8'hF0, n, cyc);
    check("t3_saw_fail_state", {31'd0, seen_ops[8]}, 32'd1);
    check("t3_no_pulse_state", {31'd0, seen_ops[3]}, 32'd0);

    // bit 3 needs three pulses
    chip_init = 8'h00;
    need[3] = 3;
    n = model_op(8'h00, 8'h08);
    check("model_t4a_n", n, 3);
    run_op(9'h100, 8'h08, n, cyc);

    // bit 3 never sets: 1 + MAX_RETRIES pulses then error
    need[3] = 0;
    n = model_op(8'h00, 8'h08);
    check("model_t4b_n", n, 4);
    run_op(9'h0FF, 8'h08, n, cyc);
    need[3] = 1;

    // already programmed word: no pulse, quick done
    chip_init = 8'h3C;
    n = model_op(8'h3C, 8'h3C);
    run_op(9'h0C3, 8'h3C, n, cyc);
    check("t5_latency_ok", {31'd0, cyc <= READ + 3}, 32'd1);

    // start held high: ignored while busy, restarts only from idle
    n = model_op(8'h3C, 8'h3C);
    @(negedge clk);
    exp_addr = 9'h055;
    bus.write_address = 9'h055;
    bus.write_data = 8'h3C;
    bus.start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_first_done", {31'd0, bus.done}, 32'd1);
    check("t6_first_cycles", cyc, READ + 1);
    @(negedge clk);
    check("t6_idle_op", {28'd0, bus.operation}, 32'd0);
    check("t6_done_persists", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    check("t6_restart_busy", {31'd0, bus.busy}, 32'd1);
    check("t6_done_cleared", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check("t6_second_done", {31'd0, bus.done}, 32'd1);
    check("t6_no_pulses", pulses_seen, 0);

    // asynchronous reset in the middle of a pulse
    chip_init = 8'h00;
    n = model_op(8'h00, 8'hFF);
    @(negedge clk);
    exp_addr = 9'h1FF;
    bus.write_address = 9'h1FF;
    bus.write_data = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.program_pulse && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t1_reached_pulse", {31'd0, bus.program_pulse}, 32'd1);
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_pulse_drop", {31'd0, bus.program_pulse}, 32'd0);
    check("t1_oe_drop", {31'd0, bus.data_oe}, 32'd0);
    check("t1_busy_drop", {31'd0, bus.busy}, 32'd0);
    check("t1_csn_high", {31'd0, bus.chip_select_n}, 32'd1);
    check("t1_op_idle", {28'd0, bus.operation}, 32'd0);
    check("t1_addr_zero", {23'd0, bus.address_line}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    mon_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_writer.md
Name: rom_writer

Overview:
- Programmer counterpart to rom_reader. It burns one word into a bipolar fuse PROM (556PT4/3601/3604 class).
- Fuses are blown bit by bit, with a timed programming pulse and read-back verify after each pulse.
- Sits between the host/control logic (start, address, data) and the chip pins: address, data drive, program strobe, chip select.
- Shares rom_reader's operation-code status style, so one status display serves both.

Parameters:
- DATA_WIDTH, 8, word width of the PROM.
- ADDRESS_WIDTH, 9, address width of the PROM.
- BLANK_VALUE, 0, logic level of an unprogrammed bit (0 or 1).
- SETUP_CYCLES, 4, clocks address/data are stable before the pulse.
- PULSE_CYCLES, 50, program_pulse high time in clocks.
- RECOVER_CYCLES, 4, clocks after the pulse before read-back.
- READ_CYCLES, 4, clocks from data_oe low to read-back sample.
- MAX_RETRIES, 3, extra pulses allowed per bit after the first failed verify.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin programming; sampled only in IDLE
- write_address  input  ADDRESS_WIDTH  target address, latched on accepted start
- write_data  input  DATA_WIDTH  target word, latched on accepted start
- data_line_in  input  DATA_WIDTH  chip outputs, for read-back
- address_line  output  ADDRESS_WIDTH  address to chip
- data_line  output  DATA_WIDTH  one-hot select of the bit being programmed
- data_oe  output  1  1 = data_line drives the chip pins
- program_pulse  output  1  programming strobe
- chip_select_n  output  1  chip enable, active low
- busy  output  1  operation in progress
- done  output  1  sticky success flag
- error  output  1  sticky failure flag
- operation  output  4  current state code

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-pulse. All outputs go to:
  - 0: address_line, data_line, data_oe, program_pulse, busy, done, error.
  - 1: chip_select_n.
  - operation = IDLE.
- State codes (operation value): IDLE 0, PRE_READ 1, SETUP 2, PULSE 3, RECOVER 4, VERIFY 5, NEXT_BIT 6, DONE 7, FAIL 8.
- IDLE:
  - When start=1: latch address and data, clear done/error, set busy=1, chip_select_n=0, address_line=latched address. Next state PRE_READ.
  - start is ignored in every other state.
- PRE_READ:
  - data_oe=0. Wait READ_CYCLES clocks, then sample data_line_in as cur.
  - If any bit has cur != BLANK_VALUE while target == BLANK_VALUE, go to FAIL (a blown fuse cannot be restored).
  - Otherwise bit index = 0, retry count = 0, go to NEXT_BIT.
- NEXT_BIT (1 clock):
  - Scan from the current index for the lowest bit with target != BLANK_VALUE and cur != target.
  - If none remains, go to DONE.
  - Otherwise set index to that bit, data_line = 1<<index, data_oe=1, go to SETUP.
- SETUP: hold for SETUP_CYCLES clocks, then PULSE.
- PULSE: program_pulse=1 for exactly PULSE_CYCLES clocks, then RECOVER.
- RECOVER: program_pulse=0, data_oe=0, data_line=0; hold RECOVER_CYCLES clocks, then VERIFY.
- VERIFY:
  - Wait READ_CYCLES clocks, then sample data_line_in[index].
  - Match: update cur, retry count = 0, index+1, go to NEXT_BIT.
  - Mismatch with retry count < MAX_RETRIES: increment retry count, re-drive data_line/data_oe, go to SETUP.
  - Mismatch with retry count = MAX_RETRIES: go to FAIL.
- DONE / FAIL: busy=0, chip_select_n=1, data_oe=0. done=1 (DONE) or error=1 (FAIL), held until the next accepted start. Return to IDLE the next clock; the flags persist.
- Timing invariants:
  - program_pulse is never high unless data_oe=1 and chip_select_n=0.
  - address_line is constant from start acceptance to DONE/FAIL.
- Timing arithmetic:
  - Single timer, wide enough for max(SETUP, PULSE, RECOVER, READ) cycles.
  - Each delay state lasts exactly its parameter count in clocks.
  - Retry counter width is clog2(MAX_RETRIES+1).
- Words needing no programming (already equal to target): PRE_READ → NEXT_BIT → DONE, no pulse issued.

Test Plan:
1. Reset: reset_n=0 while program_pulse=1 mid-PULSE → program_pulse, data_oe, busy drop immediately; chip_select_n=1; operation=0.
2. Blank chip model (reads 0x00, bit sets after 1 pulse), BLANK_VALUE=0, start with addr 0x1A5, data 0xA5 → exactly 4 pulses on data_line 0x01, 0x04, 0x20, 0x80, each 50 clocks; address_line=0x1A5 throughout; done=1, error=0.
3. Chip pre-programmed with 0x01, target 0xF0 → FAIL from PRE_READ, 0 pulses, error=1, operation passes through 8.
4. Model where bit 3 needs 3 pulses, target 0x08 → 3 pulses, done=1. Same with bit never setting → 4 pulses (1+MAX_RETRIES), then error=1.
5. Target equals current content (0x3C on chip, write 0x3C) → no program_pulse, done=1 within READ_CYCLES+3 clocks.
6. start held high through an operation and after DONE → start ignored while busy; second program begins only from IDLE; done clears on the new start.
